// File: rtl/pcie_ltssm_detect_polling.sv
// LTSSM front end: Detect.Quiet/Active and Polling.Active/Configuration with
// per-lane TS handshake counting, timeouts and lane-mask narrowing.

module pcie_ltssm_lane_cnt #(
  parameter int MATCH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic pulse_i,
  output logic sat_o
);
  localparam int CW = $clog2(MATCH + 1);
  localparam logic [CW-1:0] LAST = CW'(MATCH);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          r_cnt <= '0;
    else if (clr_i)                     r_cnt <= '0;
    else if (pulse_i && r_cnt != LAST)  r_cnt <= r_cnt + CW'(1);
  end

  assign sat_o = (r_cnt == LAST);
endmodule

module pcie_ltssm_detect_polling #(
  parameter int NUM_LANES           = 4,
  parameter int QUIET_CYCLES        = 12,
  parameter int TS1_TX_MIN          = 16,
  parameter int TS_RX_MATCH         = 8,
  parameter int TS2_TX_AFTER        = 16,
  parameter int POLL_ACTIVE_TIMEOUT = 24,
  parameter int POLL_CFG_TIMEOUT    = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] phy_layer_lane_detect_i,
  input  logic                 rx_detect_done_i,
  input  logic [NUM_LANES-1:0] rx_elec_idle_exit_i,
  input  logic [NUM_LANES-1:0] rx_ts1_valid_i,
  input  logic [NUM_LANES-1:0] rx_ts2_valid_i,
  input  logic                 tx_os_ready_i,
  input  logic                 link_down_i,
  output logic                 rx_detect_req_o,
  output logic                 tx_ts1_req_o,
  output logic                 tx_ts2_req_o,
  output logic [NUM_LANES-1:0] tx_lane_en_o,
  output logic [NUM_LANES-1:0] active_lanes_o,
  output logic [2:0]           ltssm_state_o,
  output logic                 polling_done_o,
  output logic                 en_8b10b_encoder_o
);
  localparam int QW  = $clog2(QUIET_CYCLES + 1);
  localparam int AW  = $clog2(POLL_ACTIVE_TIMEOUT + 1);
  localparam int CW  = $clog2(POLL_CFG_TIMEOUT + 1);
  localparam int S1W = $clog2(TS1_TX_MIN + 1);
  localparam int S2W = $clog2(TS2_TX_AFTER + 1);

  localparam logic [QW-1:0]  QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [AW-1:0]  PA_LAST    = AW'(POLL_ACTIVE_TIMEOUT - 1);
  localparam logic [CW-1:0]  PC_LAST    = CW'(POLL_CFG_TIMEOUT - 1);
  localparam logic [S1W-1:0] TS1_TGT    = S1W'(TS1_TX_MIN);
  localparam logic [S2W-1:0] TS2_TGT    = S2W'(TS2_TX_AFTER);

  typedef enum logic [2:0] {
    DETECT_QUIET   = 3'd0,
    DETECT_ACTIVE  = 3'd1,
    POLLING_ACTIVE = 3'd2,
    POLLING_CONFIG = 3'd3,
    CONFIG_ENTRY   = 3'd4
  } state_t;

  state_t               r_state;
  logic [NUM_LANES-1:0] r_mask;
  logic [QW-1:0]        r_quiet_tmr;
  logic [AW-1:0]        r_pa_tmr;
  logic [CW-1:0]        r_pc_tmr;
  logic [S1W-1:0]       r_ts1_sent;
  logic [S2W-1:0]       r_ts2_sent;
  logic                 r_ts2_seen;
  logic                 r_rx_detect_req;
  logic                 r_tx_ts1_req;
  logic                 r_tx_ts2_req;
  logic [NUM_LANES-1:0] r_tx_lane_en;
  logic                 r_polling_done;
  logic                 r_enc_en;

  state_t               w_nxt_state;
  logic [NUM_LANES-1:0] w_nxt_mask;
  logic                 w_chg;
  logic                 w_in_pa;
  logic                 w_in_pc;
  logic [NUM_LANES-1:0] w_sat;
  logic [NUM_LANES-1:0] w_lane_pulse;
  logic                 w_all_sat;
  logic                 w_any_sat;
  logic                 w_ts2_seen;
  logic                 w_ts1_inc;
  logic                 w_ts2_inc;
  logic                 w_pa_ok;
  logic                 w_pc_ok;

  assign w_in_pa = (r_state == POLLING_ACTIVE);
  assign w_in_pc = (r_state == POLLING_CONFIG);

  // Lanes outside the mask never count; TS1 and TS2 together still count once.
  assign w_lane_pulse = r_mask & (({NUM_LANES{w_in_pa}} & (rx_ts1_valid_i | rx_ts2_valid_i)) |
                                  ({NUM_LANES{w_in_pc}} & rx_ts2_valid_i));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pcie_ltssm_lane_cnt #(.MATCH(TS_RX_MATCH)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (w_chg),
      .pulse_i (w_lane_pulse[g]),
      .sat_o   (w_sat[g])
    );
  end

  assign w_all_sat  = &(w_sat | ~r_mask);
  assign w_any_sat  = |(w_sat & r_mask);
  // A TS2 arriving alongside an accepted send already unlocks that send.
  assign w_ts2_seen = r_ts2_seen | (w_in_pc & |(rx_ts2_valid_i & r_mask));
  assign w_ts1_inc  = w_in_pa && r_tx_ts1_req && tx_os_ready_i && (r_ts1_sent != TS1_TGT);
  assign w_ts2_inc  = w_in_pc && r_tx_ts2_req && tx_os_ready_i && w_ts2_seen &&
                      (r_ts2_sent != TS2_TGT);
  assign w_pa_ok    = (r_ts1_sent == TS1_TGT) && w_all_sat;
  assign w_pc_ok    = (r_ts2_sent == TS2_TGT) && w_all_sat;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_mask  = r_mask;
    unique case (r_state)
      DETECT_QUIET: begin
        if (r_quiet_tmr == QUIET_LAST || |rx_elec_idle_exit_i)
          w_nxt_state = DETECT_ACTIVE;
      end
      DETECT_ACTIVE: begin
        if (rx_detect_done_i) begin
          if (|phy_layer_lane_detect_i) begin
            w_nxt_state = POLLING_ACTIVE;
            w_nxt_mask  = phy_layer_lane_detect_i;
          end else begin
            w_nxt_state = DETECT_QUIET;
          end
        end
      end
      POLLING_ACTIVE: begin
        if (w_pa_ok) begin
          w_nxt_state = POLLING_CONFIG;
        end else if (r_pa_tmr == PA_LAST) begin
          if (w_any_sat) begin
            w_nxt_state = POLLING_CONFIG;
            w_nxt_mask  = w_sat & r_mask;
          end else begin
            w_nxt_state = DETECT_QUIET;
            w_nxt_mask  = '0;
          end
        end
      end
      POLLING_CONFIG: begin
        if (w_pc_ok) begin
          w_nxt_state = CONFIG_ENTRY;
        end else if (r_pc_tmr == PC_LAST) begin
          w_nxt_state = DETECT_QUIET;
          w_nxt_mask  = '0;
        end
      end
      CONFIG_ENTRY: begin
        if (link_down_i) begin
          w_nxt_state = DETECT_QUIET;
          w_nxt_mask  = '0;
        end
      end
      default: begin
        w_nxt_state = DETECT_QUIET;
        w_nxt_mask  = '0;
      end
    endcase
  end

  assign w_chg = (w_nxt_state != r_state);

  // Outputs are registered from the next state so they line up with ltssm_state_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= DETECT_QUIET;
      r_mask          <= '0;
      r_quiet_tmr     <= '0;
      r_pa_tmr        <= '0;
      r_pc_tmr        <= '0;
      r_ts1_sent      <= '0;
      r_ts2_sent      <= '0;
      r_ts2_seen      <= 1'b0;
      r_rx_detect_req <= 1'b0;
      r_tx_ts1_req    <= 1'b0;
      r_tx_ts2_req    <= 1'b0;
      r_tx_lane_en    <= '0;
      r_polling_done  <= 1'b0;
      r_enc_en        <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_mask  <= w_nxt_mask;

      if (w_chg) begin
        r_quiet_tmr <= '0;
        r_pa_tmr    <= '0;
        r_pc_tmr    <= '0;
        r_ts1_sent  <= '0;
        r_ts2_sent  <= '0;
        r_ts2_seen  <= 1'b0;
      end else begin
        if (r_state == DETECT_QUIET) r_quiet_tmr <= r_quiet_tmr + QW'(1);
        if (w_in_pa)                 r_pa_tmr    <= r_pa_tmr + AW'(1);
        if (w_in_pc)                 r_pc_tmr    <= r_pc_tmr + CW'(1);
        if (w_ts1_inc)               r_ts1_sent  <= r_ts1_sent + S1W'(1);
        if (w_ts2_inc)               r_ts2_sent  <= r_ts2_sent + S2W'(1);
        r_ts2_seen <= w_ts2_seen;
      end

      r_rx_detect_req <= (w_nxt_state == DETECT_ACTIVE);
      r_tx_ts1_req    <= (w_nxt_state == POLLING_ACTIVE);
      r_tx_ts2_req    <= (w_nxt_state == POLLING_CONFIG);
      r_tx_lane_en    <= (w_nxt_state == POLLING_ACTIVE || w_nxt_state == POLLING_CONFIG) ?
                         w_nxt_mask : '0;
      r_polling_done  <= (w_nxt_state == CONFIG_ENTRY) && (r_state != CONFIG_ENTRY);
      r_enc_en        <= (w_nxt_state == POLLING_ACTIVE) || (w_nxt_state == POLLING_CONFIG) ||
                         (w_nxt_state == CONFIG_ENTRY);
    end
  end

  assign rx_detect_req_o    = r_rx_detect_req;
  assign tx_ts1_req_o       = r_tx_ts1_req;
  assign tx_ts2_req_o       = r_tx_ts2_req;
  assign tx_lane_en_o       = r_tx_lane_en;
  assign active_lanes_o     = r_mask;
  assign ltssm_state_o      = r_state;
  assign polling_done_o     = r_polling_done;
  assign en_8b10b_encoder_o = r_enc_en;
endmodule

// File: tb/tb_pcie_ltssm_detect_polling.sv
// Directed bench for pcie_ltssm_detect_polling: detect, polling success,
// narrowing, timeouts, link_down handling and asynchronous reset.

module tb_pcie_ltssm_detect_polling;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] det, eidle, ts1, ts2;
  logic       done, ready, link_down;
  logic       req, ts1_req, ts2_req, pdone, enc;
  logic [3:0] lane_en, active;
  logic [2:0] state;
  logic [15:0] outs;

  int checks = 0;
  int failures = 0;

  pcie_ltssm_detect_polling dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .phy_layer_lane_detect_i (det),
    .rx_detect_done_i        (done),
    .rx_elec_idle_exit_i     (eidle),
    .rx_ts1_valid_i          (ts1),
    .rx_ts2_valid_i          (ts2),
    .tx_os_ready_i           (ready),
    .link_down_i             (link_down),
    .rx_detect_req_o         (req),
    .tx_ts1_req_o            (ts1_req),
    .tx_ts2_req_o            (ts2_req),
    .tx_lane_en_o            (lane_en),
    .active_lanes_o          (active),
    .ltssm_state_o           (state),
    .polling_done_o          (pdone),
    .en_8b10b_encoder_o      (enc)
  );

  always #5 clk = ~clk;

  assign outs = {req, ts1_req, ts2_req, lane_en, active, state, pdone, enc};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; det = '0; eidle = '0; ts1 = '0; ts2 = '0;
    done = 1'b0; ready = 1'b0; link_down = 1'b0;
    tick(2);
    chk("reset_outs", 32'(outs), 32'h0);

    // Idle dwell: Detect.Active on the 12th edge after reset release
    rst = 1'b0;
    tick(11);
    chk("quiet_state", 32'(state), 32'd0);
    chk("quiet_outs", 32'(outs), 32'h0);
    tick(1);
    chk("da_state", 32'(state), 32'd1);
    chk("da_req", 32'(req), 32'd1);
    chk("da_enc", 32'(enc), 32'd0);

    // Detect with no receivers -> back to quiet
    done = 1'b1; det = 4'b0000;
    tick(1);
    done = 1'b0;
    chk("da_none_state", 32'(state), 32'd0);
    chk("da_none_outs", 32'(outs), 32'h0);

    // Electrical idle exit at quiet cycle 3
    tick(3);
    eidle = 4'b0100;
    tick(1);
    eidle = '0;
    chk("eidle_state", 32'(state), 32'd1);

    done = 1'b1; det = 4'b1011;
    tick(1);
    done = 1'b0; det = '0;
    chk("pa_state", 32'(state), 32'd2);
    chk("pa_mask", 32'(active), 32'hb);
    chk("pa_lane_en", 32'(lane_en), 32'hb);
    chk("pa_ts1_req", 32'(ts1_req), 32'd1);
    chk("pa_enc", 32'(enc), 32'd1);
    chk("pa_req", 32'(req), 32'd0);

    // Polling.Active success after 16 sends, 8 TS1 per active lane
    ready = 1'b1; ts1 = 4'b1011;
    tick(8);
    ts1 = '0;
    tick(8);
    chk("pa_hold16", 32'(state), 32'd2);
    tick(1);
    chk("pc_state", 32'(state), 32'd3);
    chk("pc_ts2_req", 32'(ts2_req), 32'd1);
    chk("pc_ts1_req", 32'(ts1_req), 32'd0);
    chk("pc_mask", 32'(active), 32'hb);
    chk("pc_lane_en", 32'(lane_en), 32'hb);

    // TS2 sends only start counting once a TS2 has been received
    tick(4);
    chk("pc_gate", 32'(state), 32'd3);
    ts2 = 4'b1011;
    tick(8);
    ts2 = '0;
    tick(8);
    chk("pc_hold20", 32'(state), 32'd3);
    tick(1);
    chk("ce_state", 32'(state), 32'd4);
    chk("ce_done", 32'(pdone), 32'd1);
    chk("ce_ts2_req", 32'(ts2_req), 32'd0);
    chk("ce_lane_en", 32'(lane_en), 32'h0);
    chk("ce_enc", 32'(enc), 32'd1);
    chk("ce_mask", 32'(active), 32'hb);
    tick(1);
    chk("ce_done_pulse", 32'(pdone), 32'd0);
    chk("ce_stay", 32'(state), 32'd4);

    // link_down in Configuration entry
    ready = 1'b0; link_down = 1'b1;
    tick(1);
    link_down = 1'b0;
    chk("ld_state", 32'(state), 32'd0);
    chk("ld_outs", 32'(outs), 32'h0);

    // Narrowing on Polling.Active timeout; lane 2 gets TS1+TS2 together
    eidle = 4'b0001;
    tick(1);
    eidle = '0;
    chk("re_da", 32'(state), 32'd1);
    done = 1'b1; det = 4'b1111;
    tick(1);
    done = 1'b0; det = '0;
    chk("re_pa_mask", 32'(active), 32'hf);
    link_down = 1'b1; ts1 = 4'b0111; ts2 = 4'b0100;
    tick(1);
    link_down = 1'b0;
    chk("pa_ld_ignored", 32'(state), 32'd2);
    tick(3);
    ts1 = 4'b0011; ts2 = '0;
    tick(4);
    ts1 = '0;
    tick(15);
    chk("pa_to_hold", 32'(state), 32'd2);
    tick(1);
    chk("narrow_state", 32'(state), 32'd3);
    chk("narrow_mask", 32'(active), 32'h3);
    chk("narrow_lane_en", 32'(lane_en), 32'h3);

    // Polling.Configuration timeout
    tick(47);
    chk("pc_to_hold", 32'(state), 32'd3);
    tick(1);
    chk("pc_to_state", 32'(state), 32'd0);
    chk("pc_to_mask", 32'(active), 32'h0);

    // No lane qualifies in Polling.Active
    eidle = 4'b1000;
    tick(1);
    eidle = '0;
    done = 1'b1; det = 4'b0001;
    tick(1);
    done = 1'b0; det = '0;
    chk("nq_pa_mask", 32'(active), 32'h1);
    tick(23);
    chk("nq_hold", 32'(state), 32'd2);
    tick(1);
    chk("nq_state", 32'(state), 32'd0);
    chk("nq_mask", 32'(active), 32'h0);

    // Asynchronous reset mid Polling.Configuration
    eidle = 4'b0001;
    tick(1);
    eidle = '0;
    done = 1'b1; det = 4'b1111;
    tick(1);
    done = 1'b0; det = '0;
    ready = 1'b1; ts1 = 4'b1111;
    tick(8);
    ts1 = '0;
    tick(9);
    chk("rst_pre_pc", 32'(state), 32'd3);
    tick(2);
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", 32'(outs), 32'h0);
    tick(1);
    rst = 1'b0; ready = 1'b0;
    tick(1);
    chk("post_rst_state", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
